// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the async FIFO pointer blocks.
//   depth_of  - entry count for a given address width
//   bin2gray  - binary to reflected Gray, low 'width' bits significant
//   gray2bin  - reflected Gray to binary, low 'width' bits significant
// Functions work on a 32-bit container so one definition serves every
// pointer width; callers cast the result back to their own width.
package fifo_pkg;

    function automatic int unsigned depth_of(input int unsigned asize);
        return 32'd1 << asize;
    endfunction

    function automatic logic [31:0] width_mask(input int unsigned width);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i < width);
        end
        return m;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned width);
        logic [31:0] bm;
        bm = b & width_mask(width);
        return bm ^ (bm >> 1);
    endfunction

    // Each binary bit is the XOR of its own and all higher Gray bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned width);
        logic [31:0] gm;
        logic [31:0] b;
        gm = g & width_mask(width);
        b  = gm;
        for (int s = 1; s < 32; s++) begin
            b = b ^ (gm >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_lvl_if.sv
// wptr_full_lvl_if: write-side bus of the FIFO pointer block.
//   rd_ptr          Gray read pointer from the read domain
//   wr_inc          write request
//   wr_afull_thresh almost-full threshold (entries)
//   wr_ovf_clr      clear sticky overflow
//   wr_addr         RAM write address
//   wr_ptr          Gray write pointer to the read domain
//   wr_en           RAM write strobe
//   wr_full         full flag
//   wr_afull        almost-full flag
//   wr_level        occupancy estimate
//   wr_overflow     sticky overflow flag
// master: the writer / environment. slave: the pointer block.
interface wptr_full_lvl_if #(
    parameter int ASIZE = 4
);
    logic [ASIZE:0]   rd_ptr;
    logic             wr_inc;
    logic [ASIZE:0]   wr_afull_thresh;
    logic             wr_ovf_clr;
    logic [ASIZE-1:0] wr_addr;
    logic [ASIZE:0]   wr_ptr;
    logic             wr_en;
    logic             wr_full;
    logic             wr_afull;
    logic [ASIZE:0]   wr_level;
    logic             wr_overflow;

    modport master (
        output rd_ptr, wr_inc, wr_afull_thresh, wr_ovf_clr,
        input  wr_addr, wr_ptr, wr_en, wr_full, wr_afull, wr_level, wr_overflow
    );

    modport slave (
        input  rd_ptr, wr_inc, wr_afull_thresh, wr_ovf_clr,
        output wr_addr, wr_ptr, wr_en, wr_full, wr_afull, wr_level, wr_overflow
    );
endinterface

// File: rtl/sync_ff_n.sv
// sync_ff_n: generic multi-flop synchronizer with synchronous active-low reset.
//   wr_clk    destination clock
//   wr_rst_n  synchronous active-low reset
//   d         asynchronous input
//   q         synchronized output, STAGES clocks behind d
module sync_ff_n #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             wr_clk,
    input  logic             wr_rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];
endmodule

// File: rtl/wptr_full_lvl.sv
// wptr_full_lvl: write-domain pointer, full, level, almost-full and overflow.
//   wr_clk    write clock
//   wr_rst_n  synchronous active-low reset
//   bus       slave side of wptr_full_lvl_if (see interface header)
// The read pointer is synchronized locally; level and full are computed
// against the stale synchronized value, so they only ever over-report.
module wptr_full_lvl
    import fifo_pkg::*;
#(
    parameter int ASIZE       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          wr_clk,
    input  logic          wr_rst_n,
    wptr_full_lvl_if.slave bus
);
    localparam int unsigned DEPTH = depth_of(ASIZE);
    localparam int          PW    = $clog2(DEPTH) + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbnext;
    logic [PW-1:0] wgnext;
    logic [PW-1:0] wgray;
    logic [PW-1:0] rq;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] lvl_next;
    logic          full_q;
    logic          afull_q;
    logic [PW-1:0] level_q;
    logic          ovf_q;
    logic          wr_en;

    sync_ff_n #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .wr_clk   (wr_clk),
        .wr_rst_n (wr_rst_n),
        .d        (bus.rd_ptr),
        .q        (rq)
    );

    assign rbin_s   = PW'(gray2bin(32'(rq), PW));
    assign wr_en    = bus.wr_inc & ~full_q;
    assign wbnext   = wbin + PW'(wr_en);
    assign wgnext   = PW'(bin2gray(32'(wbnext), PW));
    assign lvl_next = wbnext - rbin_s;

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            wbin    <= '0;
            wgray   <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin    <= wbnext;
            wgray   <= wgnext;
            // Full: write pointer one lap ahead, i.e. top two Gray bits inverted.
            full_q  <= (wgnext == {~rq[PW-1:PW-2], rq[PW-3:0]});
            afull_q <= (lvl_next >= bus.wr_afull_thresh);
            level_q <= lvl_next;
            // Set takes priority so an attempt coinciding with a clear is not lost.
            if (bus.wr_inc && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.wr_ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.wr_addr     = wbin[PW-2:0];
    assign bus.wr_ptr      = wgray;
    assign bus.wr_en       = wr_en;
    assign bus.wr_full     = full_q;
    assign bus.wr_afull    = afull_q;
    assign bus.wr_level    = level_q;
    assign bus.wr_overflow = ovf_q;
endmodule

// File: tb/tb_wptr_full_lvl.sv
module tb_wptr_full_lvl;
    localparam int ASIZE = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH = 1 << ASIZE;

    typedef struct packed {
        logic [3:0] addr;
        logic [4:0] ptr;
        logic       full;
        logic       afull;
        logic [4:0] level;
        logic       ovf;
    } exp_t;

    logic wr_clk;
    logic wr_rst_n;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    // reference model state
    logic [4:0] m_wbin;
    logic       m_full;
    logic       m_ovf;
    logic [4:0] m_sync [SYNC_STAGES];

    wptr_full_lvl_if #(.ASIZE(ASIZE)) bus ();

    wptr_full_lvl #(
        .ASIZE       (ASIZE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .wr_clk   (wr_clk),
        .wr_rst_n (wr_rst_n),
        .bus      (bus)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Drive one cycle, predict the registered outputs after the edge.
    task automatic step(input logic rst_n_i, input logic inc, input logic clr, input logic [4:0] rd);
        exp_t       e;
        logic       en;
        logic [4:0] wbn;
        logic [4:0] lvl;
        wr_rst_n       = rst_n_i;
        bus.wr_inc     = inc;
        bus.wr_ovf_clr = clr;
        bus.rd_ptr     = rd;
        #1;
        if (!rst_n_i) begin
            m_wbin = '0;
            m_full = 1'b0;
            m_ovf  = 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = '0;
            e = '0;
        end else begin
            en  = inc & ~m_full;
            wbn = m_wbin + {4'd0, en};
            lvl = wbn - g2b(m_sync[SYNC_STAGES-1]);
            if (inc && m_full) m_ovf = 1'b1;
            else if (clr)      m_ovf = 1'b0;
            m_full = (lvl == 5'(DEPTH));
            m_wbin = wbn;
            for (int i = SYNC_STAGES-1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = rd;
            e.addr  = wbn[3:0];
            e.ptr   = b2g(wbn);
            e.full  = m_full;
            e.afull = (lvl >= bus.wr_afull_thresh);
            e.level = lvl;
            e.ovf   = m_ovf;
        end
        sb_q.push_back(e);
        @(posedge wr_clk);
        @(negedge wr_clk);
        #1;
    endtask

    // Scoreboard: compare every predicted cycle on the falling edge.
    always @(negedge wr_clk) begin
        exp_t e;
        exp_t a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {bus.wr_addr, bus.wr_ptr, bus.wr_full, bus.wr_afull, bus.wr_level, bus.wr_overflow};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL sb_cycle t=%0t addr/ptr/full/afull/level/ovf got %0d/%b/%b/%b/%0d/%b expected %0d/%b/%b/%b/%0d/%b",
                         $time, a.addr, a.ptr, a.full, a.afull, a.level, a.ovf,
                         e.addr, e.ptr, e.full, e.afull, e.level, e.ovf);
            end
        end
    end

    task automatic test_reset();
        bus.wr_afull_thresh = 5'd12;
        step(1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0);
        n_tests++;
        if ({bus.wr_full, bus.wr_afull, bus.wr_level, bus.wr_addr, bus.wr_ptr} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_idle full=%b afull=%b level=%0d addr=%0d ptr=%b expected all 0",
                     bus.wr_full, bus.wr_afull, bus.wr_level, bus.wr_addr, bus.wr_ptr);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 5'd0);
        n_tests++;
        if (bus.wr_full !== 1'b0 || bus.wr_level !== 5'd15) begin
            n_fail++;
            $display("FAIL fill_15 full=%b level=%0d expected full=0 level=15", bus.wr_full, bus.wr_level);
        end
        step(1'b1, 1'b1, 1'b0, 5'd0);
        n_tests++;
        if (bus.wr_full !== 1'b1 || bus.wr_level !== 5'd16 || bus.wr_addr !== 4'd0 || bus.wr_ptr !== 5'b11000) begin
            n_fail++;
            $display("FAIL fill_16 full=%b level=%0d addr=%0d ptr=%b expected 1/16/0/11000",
                     bus.wr_full, bus.wr_level, bus.wr_addr, bus.wr_ptr);
        end
    endtask

    task automatic test_overflow();
        bus.wr_inc = 1'b1;
        #1;
        n_tests++;
        if (bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_wr_en got %b expected 0", bus.wr_en);
        end
        step(1'b1, 1'b1, 1'b0, 5'd0);
        n_tests++;
        if (bus.wr_overflow !== 1'b1 || bus.wr_ptr !== 5'b11000) begin
            n_fail++;
            $display("FAIL ovf_set ovf=%b ptr=%b expected 1/11000", bus.wr_overflow, bus.wr_ptr);
        end
        step(1'b1, 1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0);
        n_tests++;
        if (bus.wr_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky got %b expected 1", bus.wr_overflow);
        end
        step(1'b1, 1'b0, 1'b1, 5'd0);
        n_tests++;
        if (bus.wr_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got %b expected 0", bus.wr_overflow);
        end
        step(1'b1, 1'b1, 1'b1, 5'd0);
        n_tests++;
        if (bus.wr_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins got %b expected 1", bus.wr_overflow);
        end
    endtask

    task automatic test_release();
        step(1'b1, 1'b0, 1'b0, b2g(5'd4));
        step(1'b1, 1'b0, 1'b0, b2g(5'd4));
        n_tests++;
        if (bus.wr_full !== 1'b1) begin
            n_fail++;
            $display("FAIL release_early full=%b expected 1", bus.wr_full);
        end
        step(1'b1, 1'b0, 1'b0, b2g(5'd4));
        n_tests++;
        if (bus.wr_full !== 1'b0 || bus.wr_level !== 5'd12 || bus.wr_afull !== 1'b1) begin
            n_fail++;
            $display("FAIL release_4 full=%b level=%0d afull=%b expected 0/12/1",
                     bus.wr_full, bus.wr_level, bus.wr_afull);
        end
        for (int i = 0; i < SYNC_STAGES + 1; i++) step(1'b1, 1'b0, 1'b0, b2g(5'd5));
        n_tests++;
        if (bus.wr_afull !== 1'b0 || bus.wr_level !== 5'd11) begin
            n_fail++;
            $display("FAIL release_5 afull=%b level=%0d expected 0/11", bus.wr_afull, bus.wr_level);
        end
    endtask

    task automatic test_stream();
        logic [4:0] rd;
        for (int r = 6; r <= 14; r++) step(1'b1, 1'b0, 1'b0, b2g(5'(r)));
        for (int i = 0; i < SYNC_STAGES + 1; i++) step(1'b1, 1'b0, 1'b0, b2g(5'd14));
        for (int i = 0; i < 40; i++) begin
            rd = m_wbin - 5'd2;
            step(1'b1, 1'b1, 1'b0, b2g(rd));
            n_tests++;
            if (bus.wr_full !== 1'b0 || bus.wr_level < 5'd2 || bus.wr_level > 5'd5) begin
                n_fail++;
                $display("FAIL stream_%0d full=%b level=%0d expected full=0 level 2..5",
                         i, bus.wr_full, bus.wr_level);
            end
        end
        n_tests++;
        if (bus.wr_addr !== 4'd8 || bus.wr_ptr !== 5'b10100) begin
            n_fail++;
            $display("FAIL stream_wrap addr=%0d ptr=%b expected 8/10100", bus.wr_addr, bus.wr_ptr);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < SYNC_STAGES + 1; i++) step(1'b1, 1'b0, 1'b0, b2g(5'd21));
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, b2g(5'd21));
        n_tests++;
        if (bus.wr_level !== 5'd9 || bus.wr_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset level=%0d ovf=%b expected 9/1", bus.wr_level, bus.wr_overflow);
        end
        step(1'b0, 1'b1, 1'b0, 5'd0);
        n_tests++;
        if ({bus.wr_full, bus.wr_afull, bus.wr_level, bus.wr_addr, bus.wr_ptr, bus.wr_overflow} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid full=%b afull=%b level=%0d addr=%0d ptr=%b ovf=%b expected all 0",
                     bus.wr_full, bus.wr_afull, bus.wr_level, bus.wr_addr, bus.wr_ptr, bus.wr_overflow);
        end
        step(1'b1, 1'b0, 1'b0, 5'd0);
        n_tests++;
        if (bus.wr_level !== 5'd0 || bus.wr_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_inc_ignored level=%0d addr=%0d expected 0/0", bus.wr_level, bus.wr_addr);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        wr_rst_n = 1'b0;
        bus.wr_inc = 1'b0;
        bus.wr_ovf_clr = 1'b0;
        bus.rd_ptr = '0;
        bus.wr_afull_thresh = 5'd12;
        @(negedge wr_clk);
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_stream();
        test_reset_mid();
        repeat (2) @(negedge wr_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
